// File: rtl/cache_arbiter.sv
// ---------------------------------------------------------------------------
// cache_arbiter
//
// Purpose:
//   Shares the single physical-memory line port between the split L1 caches.
//   Instruction-cache fills and data-cache fills/writebacks are serialised
//   one whole line at a time. When both caches are waiting, the grant
//   alternates between them (round-robin). After reset the data side wins
//   the first contention.
//
//   Every transfer moves through three steps:
//     IDLE -> pick a requester and latch its address, op and write line
//     MEM  -> drive the latched request until memory answers
//     RESP -> pulse the owner's resp for one cycle with the captured line
//
// Ports:
//   clk, rst          system clock; asynchronous active-high reset
//   i_read            icache line-fill request (held until i_resp)
//   i_address         icache line address
//   i_rdata, i_resp   fill line and one-cycle completion pulse to icache
//   d_read, d_write   dcache fill / writeback request (held until d_resp)
//   d_address         dcache line address
//   d_wdata           dcache writeback line
//   d_rdata, d_resp   fill line and one-cycle completion pulse to dcache
//   pmem_read/write   line request to physical memory (never both high)
//   pmem_address      line address to physical memory
//   pmem_wdata        write line to physical memory
//   pmem_rdata        read line from physical memory, valid with pmem_resp
//   pmem_resp         one-cycle completion from physical memory
// ---------------------------------------------------------------------------
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [1:0]        state_q,      state_d;
    logic              owner_q,      owner_d;
    logic              last_grant_q, last_grant_d;
    logic              op_write_q,   op_write_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [LINE_W-1:0] wdata_q,      wdata_d;
    logic [LINE_W-1:0] i_rdata_q,    i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q,    d_rdata_d;

    logic req_i;
    logic req_d;
    logic grant_to_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // The data side wins when it is the only requester, or when both are
    // waiting and the instruction side held the previous grant.
    assign grant_to_d = req_d & (~req_i | (last_grant_q == OWN_I));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_write_d   = op_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i | req_d) begin
                    owner_d      = grant_to_d ? OWN_D : OWN_I;
                    last_grant_d = grant_to_d ? OWN_D : OWN_I;
                    // d_read together with d_write is treated as a writeback,
                    // so only one pmem strobe can ever be raised.
                    op_write_d   = grant_to_d & d_write;
                    addr_d       = grant_to_d ? d_address : i_address;
                    wdata_d      = d_wdata;
                    state_d      = ST_MEM;
                end
            end

            ST_MEM: begin
                if (pmem_resp) begin
                    // Writebacks also refresh d_rdata; the dcache ignores it.
                    if (owner_q == OWN_D) begin
                        d_rdata_d = pmem_rdata;
                    end else begin
                        i_rdata_d = pmem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end

            ST_RESP: begin
                // The requester drops its request at the end of this cycle,
                // so going straight back to IDLE never sees a stale request.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_write_q   <= op_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Strobes and resps decode straight from the state register, so an
    // asynchronous reset drops them in the same instant.
    assign pmem_read    = (state_q == ST_MEM) & ~op_write_q;
    assign pmem_write   = (state_q == ST_MEM) &  op_write_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    assign i_resp  = (state_q == ST_RESP) & (owner_q == OWN_I);
    assign d_resp  = (state_q == ST_RESP) & (owner_q == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    // Called in the first cycle the granted request should be on pmem.
    // Holds memory busy for a few cycles, answers with 'line', checks the
    // owner's resp pulse and leaves the bench in the idle cycle afterwards.
    task automatic serve(input string tag, input bit exp_d, input bit exp_wr,
                         input logic [ADDR_W-1:0] exp_addr,
                         input logic [LINE_W-1:0] exp_wdata,
                         input logic [LINE_W-1:0] line);
        chk({tag, ".pread"},  pmem_read,  !exp_wr);
        chk({tag, ".pwrite"}, pmem_write, exp_wr);
        chk({tag, ".paddr"},  pmem_address, exp_addr);
        if (exp_wr) chk({tag, ".pwdata"}, pmem_wdata, exp_wdata);
        // Requester inputs may wander after the grant; pmem must not follow.
        if (exp_d) begin
            d_address = d_address ^ 32'h40;
            d_wdata   = ~d_wdata;
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            chk({tag, ".hold_rd"},   pmem_read,  !exp_wr);
            chk({tag, ".hold_wr"},   pmem_write, exp_wr);
            chk({tag, ".hold_addr"}, pmem_address, exp_addr);
            if (exp_wr) chk({tag, ".hold_wdata"}, pmem_wdata, exp_wdata);
            chk({tag, ".early_iresp"}, i_resp, 1'b0);
            chk({tag, ".early_dresp"}, d_resp, 1'b0);
        end
        pmem_rdata = line;
        pmem_resp  = 1'b1;
        tick();
        pmem_resp  = 1'b0;
        chk({tag, ".drop_rd"}, pmem_read,  1'b0);
        chk({tag, ".drop_wr"}, pmem_write, 1'b0);
        chk({tag, ".iresp"},   i_resp, !exp_d);
        chk({tag, ".dresp"},   d_resp, exp_d);
        chk({tag, ".rdata"},   exp_d ? d_rdata : i_rdata, line);
        if (exp_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        tick();
        chk({tag, ".iresp_once"}, i_resp, 1'b0);
        chk({tag, ".dresp_once"}, d_resp, 1'b0);
        chk({tag, ".idle_rd"},    pmem_read,  1'b0);
        chk({tag, ".idle_wr"},    pmem_write, 1'b0);
    endtask

    // Transaction-level reference for the random phase.
    int                m_ph;      // 0 arbiter free, 1 line on pmem, 2 completion cycle
    bit                m_own_d;
    bit                m_last_d;
    bit                m_wr;
    bit                m_win;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_irdata;
    logic [LINE_W-1:0] m_drdata;
    int                mwait;
    bit                dropped_i;
    bit                dropped_d;
    int                r;

    initial begin
        rst        = 1'b1;
        i_read     = 1'b0;
        i_address  = '0;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_address  = '0;
        d_wdata    = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;

        tick();
        tick();
        chk("rst.pread",  pmem_read,  1'b0);
        chk("rst.pwrite", pmem_write, 1'b0);
        chk("rst.iresp",  i_resp,     1'b0);
        chk("rst.dresp",  d_resp,     1'b0);
        chk("rst.irdata", i_rdata,    '0);
        chk("rst.drdata", d_rdata,    '0);
        chk("rst.paddr",  pmem_address, '0);
        rst = 1'b0;
        tick();

        // Single icache fill
        i_read    = 1'b1;
        i_address = 32'h0000_0060;
        tick();
        serve("ifill", 1'b0, 1'b0, 32'h0000_0060, '0, {8{32'hDEAD_BEEF}});

        // Dcache writeback
        d_write   = 1'b1;
        d_address = 32'h0000_1020;
        d_wdata   = {8{32'h1234_5678}};
        tick();
        serve("dwb", 1'b1, 1'b1, 32'h0000_1020, {8{32'h1234_5678}}, rand_line());

        // Simultaneous requests straight after reset: D first, then I
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        i_read    = 1'b1;
        i_address = 32'h0000_0300;
        d_read    = 1'b1;
        d_address = 32'h0000_0400;
        tick();
        serve("simD", 1'b1, 1'b0, 32'h0000_0400, '0, rand_line());
        tick();
        serve("simI", 1'b0, 1'b0, 32'h0000_0300, '0, rand_line());

        // Fairness under continuous contention
        i_read    = 1'b1;
        i_address = 32'h0000_0100;
        d_read    = 1'b1;
        d_address = 32'h0000_0200;
        for (int k = 0; k < 6; k++) begin
            tick();
            serve("fair", (k % 2) == 0, 1'b0, ((k % 2) == 0) ? 32'h0000_0200 : 32'h0000_0100, '0, rand_line());
            if ((k % 2) == 0) begin
                d_read    = 1'b1;
                d_address = 32'h0000_0200;
            end else begin
                i_read = 1'b1;
            end
        end
        i_read = 1'b0;
        d_read = 1'b0;
        tick();

        // Reset in the middle of a fill
        i_read    = 1'b1;
        i_address = 32'h0000_0500;
        tick();
        chk("mrst.pre_rd", pmem_read, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.rd_now", pmem_read, 1'b0);
        chk("mrst.iresp",  i_resp,    1'b0);
        chk("mrst.dresp",  d_resp,    1'b0);
        i_read = 1'b0;
        #2;
        rst        = 1'b0;
        pmem_rdata = rand_line();
        pmem_resp  = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("mrst.late_iresp", i_resp,    1'b0);
        chk("mrst.late_dresp", d_resp,    1'b0);
        chk("mrst.late_rd",    pmem_read, 1'b0);
        tick();
        chk("mrst.late_iresp2", i_resp,  1'b0);
        chk("mrst.late_dresp2", d_resp,  1'b0);
        chk("mrst.irdata",      i_rdata, '0);
        i_read    = 1'b1;
        i_address = 32'h0000_0540;
        tick();
        serve("post_rst", 1'b0, 1'b0, 32'h0000_0540, '0, rand_line());

        // Spurious pmem_resp while idle
        pmem_rdata = rand_line();
        pmem_resp  = 1'b1;
        tick();
        pmem_resp = 1'b0;
        chk("spur.iresp", i_resp,     1'b0);
        chk("spur.dresp", d_resp,     1'b0);
        chk("spur.rd",    pmem_read,  1'b0);
        chk("spur.wr",    pmem_write, 1'b0);
        tick();
        chk("spur.iresp2", i_resp, 1'b0);
        chk("spur.dresp2", d_resp, 1'b0);

        // Illegal d_read together with d_write behaves as a writeback
        d_read    = 1'b1;
        d_write   = 1'b1;
        d_address = 32'h0000_2000;
        d_wdata   = rand_line();
        m_wdata   = d_wdata;
        tick();
        serve("illegal", 1'b1, 1'b1, 32'h0000_2000, m_wdata, rand_line());

        // Randomised traffic against the transaction-level reference
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        m_ph      = 0;
        m_own_d   = 1'b0;
        m_last_d  = 1'b0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_irdata  = '0;
        m_drdata  = '0;
        mwait     = 2;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (m_ph == 0) begin
                if (i_read || d_read || d_write) begin
                    m_win    = (d_read || d_write) && (!i_read || !m_last_d);
                    m_own_d  = m_win;
                    m_last_d = m_win;
                    m_wr     = m_win && d_write;
                    m_addr   = m_win ? d_address : i_address;
                    m_wdata  = d_wdata;
                    m_ph     = 1;
                end
            end else if (m_ph == 1) begin
                if (pmem_resp) begin
                    if (m_own_d) m_drdata = pmem_rdata;
                    else         m_irdata = pmem_rdata;
                    m_ph = 2;
                end
            end else begin
                m_ph = 0;
            end

            chk("r.pread",  pmem_read,  (m_ph == 1) && !m_wr);
            chk("r.pwrite", pmem_write, (m_ph == 1) && m_wr);
            chk("r.excl",   pmem_read & pmem_write, 1'b0);
            chk("r.iresp",  i_resp, (m_ph == 2) && !m_own_d);
            chk("r.dresp",  d_resp, (m_ph == 2) && m_own_d);
            chk("r.irdata", i_rdata, m_irdata);
            chk("r.drdata", d_rdata, m_drdata);
            if (m_ph == 1) chk("r.paddr", pmem_address, m_addr);
            if (m_ph == 1 && m_wr) chk("r.pwdata", pmem_wdata, m_wdata);

            dropped_i = 1'b0;
            dropped_d = 1'b0;
            if (m_ph == 2) begin
                if (m_own_d) begin
                    d_read    = 1'b0;
                    d_write   = 1'b0;
                    dropped_d = 1'b1;
                end else begin
                    i_read    = 1'b0;
                    dropped_i = 1'b1;
                end
            end
            if (!i_read && !dropped_i && $urandom_range(0, 3) == 0) begin
                i_read    = 1'b1;
                i_address = $urandom() & ~32'h1F;
            end
            if (!d_read && !d_write && !dropped_d && $urandom_range(0, 3) == 0) begin
                r         = $urandom_range(0, 7);
                d_read    = (r < 3) || (r == 7);
                d_write   = (r >= 3);
                d_address = $urandom() & ~32'h1F;
                d_wdata   = rand_line();
            end

            if ((pmem_read || pmem_write) && !pmem_resp) begin
                if (mwait == 0) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = rand_line();
                end else begin
                    mwait--;
                end
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
                mwait     = $urandom_range(0, 4);
            end else if (m_ph != 1 && $urandom_range(0, 9) == 0) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rand_line();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits between the split L1 caches (instruction and data) and the single physical-memory line port at the mp4 top level.
- Serialises cache-line misses and writebacks from both caches onto one pmem read/write/resp channel.
- Arbitration is round-robin on contention.
- Transfers are whole cache lines (256 bits). The burst adaptor or memory model behind pmem handles beat sequencing.

Parameters:
- LINE_W, 256, cache line width in bits for all rdata/wdata buses.
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_read  input  1  icache line-fill request; held until i_resp.
- i_address  input  ADDR_W  icache line address (line-aligned).
- i_rdata  output  LINE_W  fill data to icache; valid while i_resp=1.
- i_resp  output  1  one-cycle completion pulse to icache.
- d_read  input  1  dcache line-fill request; held until d_resp.
- d_write  input  1  dcache writeback request; held until d_resp.
- d_address  input  ADDR_W  dcache line address.
- d_wdata  input  LINE_W  dcache writeback line.
- d_rdata  output  LINE_W  fill data to dcache; valid while d_resp=1.
- d_resp  output  1  one-cycle completion pulse to dcache.
- pmem_read  output  1  line read request to physical memory.
- pmem_write  output  1  line write request to physical memory.
- pmem_address  output  ADDR_W  line address to physical memory.
- pmem_wdata  output  LINE_W  write line to physical memory.
- pmem_rdata  input  LINE_W  read line from physical memory; valid with pmem_resp.
- pmem_resp  input  1  physical memory completion (one cycle).

Behaviour:
- Reset (async, immediate): state=IDLE, last_grant=I (so D wins first contention), all outputs 0, captured data registers 0.
- State IDLE:
  - Evaluate requests. req_i=i_read; req_d=d_read|d_write.
  - If exactly one is pending, grant it.
  - If both are pending, grant the side opposite last_grant.
  - On grant, at the edge: latch owner, address, op (read/write), and d_wdata; update last_grant; go to MEM.
  - No request: stay in IDLE.
- State MEM:
  - pmem_read/pmem_write and pmem_address/pmem_wdata are driven from the latched registers, so inputs may change freely after the grant.
  - They are held stable until pmem_resp.
  - On pmem_resp: capture pmem_rdata into the owner's rdata register; go to RESP.
  - pmem_read and pmem_write drop at that same edge.
- State RESP:
  - Assert the owner's resp for exactly one cycle with rdata valid. The other side's resp stays 0.
  - Return to IDLE.
  - rdata registers hold their value until the next capture.
- Latency:
  - Request high at edge k in IDLE → pmem_read/pmem_write high in cycle k+1.
  - pmem_resp in cycle n → owner resp high in cycle n+1.
  - Earliest next grant at the edge ending cycle n+2, i.e. minimum 1 idle cycle between pmem transactions.
- The requester drops its request at the edge ending its resp cycle; IDLE must not see a stale request.
- d_read and d_write both high is illegal. The arbiter treats it as a write: pmem_write=1, pmem_read=0, never both.
- pmem_read and pmem_write are never both 1 in any cycle.
- pmem_resp in IDLE or RESP is ignored: no state change, no resp pulse.
- A request arriving while the other side is in MEM/RESP waits; no preemption.
- Reset during MEM or RESP:
  - pmem_read/write and resps drop immediately.
  - A pmem_resp arriving after reset release while in IDLE is ignored.
- Write responses: d_rdata is updated with pmem_rdata (don't-care) on write completion; the dcache must ignore it.

Test Plan:
- Single icache fill:
  - Stimulus: i_read=1, i_address=0x0000_0060; pmem_resp after 5 cycles with pmem_rdata = {8{32'hDEAD_BEEF}}.
  - Required: pmem_read=1 and pmem_address=0x60 one cycle after request; i_resp=1 for exactly 1 cycle, one cycle after pmem_resp, with i_rdata equal to that line; d_resp never asserted.
- Dcache writeback:
  - Stimulus: d_write=1, d_address=0x0000_1020, d_wdata={8{32'h1234_5678}}.
  - Required: pmem_write=1 with pmem_wdata equal to that line and pmem_address=0x1020; pmem_read=0 throughout; d_resp pulse after pmem_resp.
- Simultaneous requests after reset:
  - Stimulus: i_read and d_read asserted in the same cycle.
  - Required: D granted first (pmem_address=d_address); after d_resp, I is granted with one idle cycle between.
- Fairness:
  - Stimulus: both sides re-request continuously for 6 transactions.
  - Required: grants strictly alternate D,I,D,I,D,I.
- Reset mid-transaction:
  - Stimulus: assert rst in MEM between clock edges; release; then pulse pmem_resp.
  - Required: pmem_read falls immediately at rst; no i_resp or d_resp; state IDLE.
- Spurious and illegal inputs:
  - Stimulus: pmem_resp while IDLE.
  - Required: no resp outputs.
  - Stimulus: d_read=d_write=1.
  - Required: only pmem_write asserted.
